// File: rtl/fetch_sequencer.sv
// Instruction-fetch controller: owns the PC, holds each memory address for
// WAIT_CYCLES cycles, captures the word into a 2-entry queue feeding decode.
module fetch_sequencer #(
  parameter int unsigned                ADDR_WIDTH  = 64,
  parameter logic [ADDR_WIDTH-1:0]      RESET_PC    = '0,
  parameter int unsigned                WAIT_CYCLES = 2
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  enable,
  input  logic                  redirect_valid,
  input  logic [ADDR_WIDTH-1:0] redirect_address,
  output logic [ADDR_WIDTH-1:0] imem_address,
  input  logic [31:0]           imem_data,
  output logic                  inst_valid,
  input  logic                  inst_ready,
  output logic [31:0]           inst_data,
  output logic [ADDR_WIDTH-1:0] inst_pc,
  output logic                  fetch_error
);

  typedef enum logic [1:0] {IDLE, ACCESS, ERROR} state_t;

  localparam logic [3:0] WAIT_LOAD = 4'(WAIT_CYCLES - 1);

  state_t                r_state, w_state_next;
  logic [3:0]            r_wait;
  logic [ADDR_WIDTH-1:0] r_fetch_pc;
  logic [ADDR_WIDTH-1:0] r_q_pc   [2];
  logic [31:0]           r_q_data [2];
  logic [1:0]            r_count;
  logic                  r_error;

  logic                  w_pop, w_push, w_last, w_start;
  logic                  w_redirect, w_misaligned;
  logic [1:0]            w_occ_after, w_slot;

  assign w_last       = (r_state == ACCESS) && (r_wait == 4'd0);
  assign w_redirect   = redirect_valid && (r_state != ERROR);
  assign w_misaligned = (redirect_address[1:0] != 2'b00);
  assign w_pop        = inst_valid && inst_ready;
  assign w_push       = w_last && !w_redirect;
  assign w_occ_after  = r_count + 2'(w_push) - 2'(w_pop);
  // Slot for the incoming entry once the head has (possibly) shifted out.
  assign w_slot       = r_count - 2'(w_pop);

  always_comb begin
    w_state_next = r_state;
    w_start      = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (w_redirect) begin
          w_state_next = w_misaligned ? ERROR : IDLE;
        end else if (enable && (r_count != 2'd2)) begin
          w_state_next = ACCESS;
          w_start      = 1'b1;
        end
      end
      ACCESS: begin
        if (w_redirect) begin
          w_state_next = w_misaligned ? ERROR : IDLE;
        end else if (w_last) begin
          if (enable && (w_occ_after < 2'd2)) begin
            w_start = 1'b1;
          end else begin
            w_state_next = IDLE;
          end
        end
      end
      ERROR:   w_state_next = ERROR;
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) r_state <= IDLE;
    else          r_state <= w_state_next;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_wait      <= '0;
      r_fetch_pc  <= RESET_PC;
      r_count     <= '0;
      r_error     <= 1'b0;
      r_q_pc[0]   <= '0;
      r_q_pc[1]   <= '0;
      r_q_data[0] <= '0;
      r_q_data[1] <= '0;
    end else begin
      if (w_start)                                r_wait <= WAIT_LOAD;
      else if (r_state == ACCESS && r_wait != '0) r_wait <= r_wait - 4'd1;

      if (w_redirect) begin
        r_count <= '0;
        if (w_misaligned) r_error    <= 1'b1;
        else              r_fetch_pc <= redirect_address;
      end else begin
        if (w_pop) begin
          r_q_pc[0]   <= r_q_pc[1];
          r_q_data[0] <= r_q_data[1];
        end
        // A push issued after the shift overrides it when both target slot 0.
        if (w_push) begin
          r_q_pc[w_slot[0]]   <= r_fetch_pc;
          r_q_data[w_slot[0]] <= imem_data;
          r_fetch_pc          <= r_fetch_pc + ADDR_WIDTH'(4);
        end
        r_count <= w_occ_after;
      end
    end
  end

  assign imem_address = r_fetch_pc;
  assign inst_valid   = (r_count != 2'd0) && (r_state != ERROR);
  assign inst_data    = r_q_data[0];
  assign inst_pc      = r_q_pc[0];
  assign fetch_error  = r_error;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: queue-based scoreboard of expected fetch PCs,
// popped on every decode handshake, plus cycle-exact spot checks.
module tb_fetch_sequencer;

  localparam int unsigned AW       = 64;
  localparam logic [31:0] DATA_KEY = 32'hC0DE_0000;

  logic          clk = 1'b0;
  logic          reset_n, enable, redirect_valid, inst_ready;
  logic [AW-1:0] redirect_address;
  logic [AW-1:0] imem_address, inst_pc;
  logic [31:0]   imem_data, inst_data;
  logic          inst_valid, fetch_error;

  int unsigned   n_vec  = 0;
  int unsigned   n_miss = 0;
  logic [AW-1:0] exp_q[$];
  logic [AW-1:0] mon_pc;

  always #5 clk = ~clk;

  assign imem_data = imem_address[31:0] ^ DATA_KEY;

  fetch_sequencer #(
    .ADDR_WIDTH (AW),
    .RESET_PC   (64'h0),
    .WAIT_CYCLES(2)
  ) dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .enable          (enable),
    .redirect_valid  (redirect_valid),
    .redirect_address(redirect_address),
    .imem_address    (imem_address),
    .imem_data       (imem_data),
    .inst_valid      (inst_valid),
    .inst_ready      (inst_ready),
    .inst_data       (inst_data),
    .inst_pc         (inst_pc),
    .fetch_error     (fetch_error)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic nxt_n(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) nxt();
  endtask

  task automatic do_reset();
    reset_n        = 1'b0;
    redirect_valid = 1'b0;
    nxt();
    reset_n = 1'b1;
    check_eq("rst_valid", 64'(inst_valid), 64'd0);
    check_eq("rst_imem",  imem_address, 64'h0);
    check_eq("rst_pc",    inst_pc, 64'h0);
    check_eq("rst_data",  64'(inst_data), 64'h0);
    check_eq("rst_err",   64'(fetch_error), 64'd0);
  endtask

  task automatic head_is(input string tag, input logic [63:0] pc);
    check_eq({tag, "_valid"}, 64'(inst_valid), 64'd1);
    check_eq({tag, "_pc"}, inst_pc, pc);
  endtask

  // Every handshake must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (reset_n && inst_valid && inst_ready) begin
      if (exp_q.size() == 0) begin
        check_eq("sb_underflow", 64'(exp_q.size()), 64'd1);
      end else begin
        mon_pc = exp_q.pop_front();
        check_eq("sb_pc", inst_pc, mon_pc);
        check_eq("sb_data", 64'(inst_data), 64'(mon_pc[31:0] ^ DATA_KEY));
      end
    end
  end

  initial begin
    reset_n = 1'b0; enable = 1'b0; redirect_valid = 1'b0;
    inst_ready = 1'b0; redirect_address = '0;
    nxt_n(2);

    // Streaming with ready high; enable dropped mid-ACCESS of pc 12.
    enable = 1'b1; inst_ready = 1'b1;
    exp_q.push_back(64'h0); exp_q.push_back(64'h4);
    exp_q.push_back(64'h8); exp_q.push_back(64'hC);
    do_reset();
    nxt(); check_eq("t1_c1_valid", 64'(inst_valid), 64'd0);
    nxt(); check_eq("t1_c2_valid", 64'(inst_valid), 64'd0);
    check_eq("t1_c2_imem", imem_address, 64'h0);
    nxt(); head_is("t1_c3", 64'h0);
    check_eq("t1_c3_imem", imem_address, 64'h4);
    nxt(); check_eq("t1_c4_valid", 64'(inst_valid), 64'd0);
    nxt(); head_is("t1_c5", 64'h4);
    nxt_n(2); head_is("t1_c7", 64'h8);
    enable = 1'b0;
    nxt_n(2); head_is("t1_c9", 64'hC);
    check_eq("t1_c9_imem", imem_address, 64'h10);
    nxt(); check_eq("t1_c10_valid", 64'(inst_valid), 64'd0);
    nxt_n(2); check_eq("t1_c12_imem", imem_address, 64'h10);
    check_eq("t1_c12_valid", 64'(inst_valid), 64'd0);

    // Back-pressure: queue fills, fetch parks at 8, then drains and resumes.
    enable = 1'b1; inst_ready = 1'b0;
    exp_q.push_back(64'h0); exp_q.push_back(64'h4); exp_q.push_back(64'h8);
    do_reset();
    nxt_n(3); head_is("t2_c3", 64'h0);
    nxt_n(5); head_is("t2_c8", 64'h0);
    check_eq("t2_c8_imem", imem_address, 64'h8);
    inst_ready = 1'b1;
    nxt(); head_is("t2_c9", 64'h4);
    nxt(); check_eq("t2_c10_valid", 64'(inst_valid), 64'd0);
    check_eq("t2_c10_imem", imem_address, 64'h8);
    enable = 1'b0;
    nxt_n(2); head_is("t2_c12", 64'h8);
    check_eq("t2_c12_imem", imem_address, 64'hC);
    nxt(); check_eq("t2_c13_valid", 64'(inst_valid), 64'd0);
    nxt_n(2); check_eq("t2_c15_imem", imem_address, 64'hC);

    // Aligned redirect on the capture edge with one entry queued.
    enable = 1'b1; inst_ready = 1'b0;
    do_reset();
    nxt_n(4); head_is("t3_c4", 64'h0);
    redirect_valid = 1'b1; redirect_address = 64'h40;
    exp_q.push_back(64'h40); exp_q.push_back(64'h44);
    nxt(); redirect_valid = 1'b0; inst_ready = 1'b1;
    check_eq("t3_c5_valid", 64'(inst_valid), 64'd0);
    check_eq("t3_c5_imem", imem_address, 64'h40);
    nxt_n(2); check_eq("t3_c7_valid", 64'(inst_valid), 64'd0);
    nxt(); head_is("t3_c8", 64'h40);
    enable = 1'b0;
    nxt_n(2); head_is("t3_c10", 64'h44);
    nxt(); check_eq("t3_c11_valid", 64'(inst_valid), 64'd0);
    check_eq("t3_c11_imem", imem_address, 64'h48);

    // Misaligned redirect: sticky error, everything else ignored.
    enable = 1'b1; inst_ready = 1'b1;
    exp_q.push_back(64'h0);
    do_reset();
    nxt_n(3); head_is("t4_c3", 64'h0);
    redirect_valid = 1'b1; redirect_address = 64'h42;
    nxt(); redirect_address = 64'h80;
    check_eq("t4_c4_err", 64'(fetch_error), 64'd1);
    check_eq("t4_c4_valid", 64'(inst_valid), 64'd0);
    check_eq("t4_c4_imem", imem_address, 64'h4);
    nxt(); redirect_valid = 1'b0;
    check_eq("t4_c5_imem", imem_address, 64'h4);
    nxt_n(5);
    check_eq("t4_c10_err", 64'(fetch_error), 64'd1);
    check_eq("t4_c10_valid", 64'(inst_valid), 64'd0);
    check_eq("t4_c10_imem", imem_address, 64'h4);

    // Reset mid-ACCESS with an entry queued, then PC wrap at the top of memory.
    enable = 1'b1; inst_ready = 1'b0;
    exp_q.push_back(64'h0);
    do_reset();
    nxt_n(5); head_is("t5_c5", 64'h0);
    check_eq("t5_c5_imem", imem_address, 64'h8);
    inst_ready = 1'b1;
    nxt(); inst_ready = 1'b0; head_is("t5_c6", 64'h4);
    nxt(); check_eq("t5_c7_imem", imem_address, 64'h8);
    enable = 1'b1; inst_ready = 1'b1;
    exp_q.push_back(64'h0);
    do_reset();
    nxt_n(3); head_is("t6_c3", 64'h0);
    redirect_valid = 1'b1; redirect_address = 64'hFFFF_FFFF_FFFF_FFFC;
    exp_q.push_back(64'hFFFF_FFFF_FFFF_FFFC);
    nxt(); redirect_valid = 1'b0;
    check_eq("t6_c4_valid", 64'(inst_valid), 64'd0);
    nxt(); check_eq("t6_c5_imem", imem_address, 64'hFFFF_FFFF_FFFF_FFFC);
    enable = 1'b0;
    nxt_n(2); head_is("t6_c7", 64'hFFFF_FFFF_FFFF_FFFC);
    check_eq("t6_c7_imem", imem_address, 64'h0);
    nxt(); check_eq("t6_c8_valid", 64'(inst_valid), 64'd0);
    nxt(); check_eq("t6_c9_imem", imem_address, 64'h0);

    check_eq("sb_drain", 64'(exp_q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
